r_station_q: RTL and testbench

- Parametrised successor of the single-bundle reservation station.
- Sits between the decoder (id_*) and the execution scheduler (ex_*).
- Buffers up to DEPTH decoded micro-op bundles, each with up to SLOTS uops and a DATA_W operand.
- Issues one uop per scheduler ack in program order and lets memory overwrite the head bundle's operand.

---
 rtl/r_station_pkg.sv | 30 +++
 rtl/r_station_q_if.sv | 44 ++++
 rtl/r_station_q_bundle_mem.sv | 56 +++++
 rtl/r_station_q.sv | 104 ++++++++++
 tb/tb_r_station_q.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/r_station_pkg.sv
// Shared constants and width helpers for the bundle reservation station.
// Imported by the interface, the storage block and the control top.
package r_station_pkg;

    localparam int unsigned DEF_UOP_W  = 20;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_SLOTS  = 3;
    localparam int unsigned DEF_DEPTH  = 4;

    localparam logic [19:0] NOP_UOP = 20'h00F00;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned n);
        return $clog2(n);
    endfunction

    function automatic int unsigned slot_lsb(input int unsigned idx,
                                             input int unsigned w);
        return idx * w;
    endfunction

    function automatic int unsigned sat_count(input int unsigned c,
                                              input int unsigned s);
        return (c > s) ? s : c;
    endfunction

endpackage

// File: rtl/r_station_q_if.sv
// Decoder, scheduler and memory-side signals of the reservation station.
// The station binds the slave modport; its environment binds master.
interface r_station_q_if
    import r_station_pkg::*;
#(
    parameter int unsigned UOP_W  = DEF_UOP_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned SLOTS  = DEF_SLOTS,
    parameter int unsigned DEPTH  = DEF_DEPTH
) ();

    localparam int unsigned CW    = cnt_w(SLOTS);
    localparam int unsigned OCC_W = cnt_w(DEPTH);

    logic                   id_valid;
    logic                   id_ready;
    logic [SLOTS*UOP_W-1:0] id_uops;
    logic [CW-1:0]          id_uop_count;
    logic [DATA_W-1:0]      id_k16;
    logic [UOP_W-1:0]       ex_uop_next;
    logic                   ex_uop_valid;
    logic                   ex_sched_ack;
    logic [UOP_W-1:0]       ex_uop_last;
    logic [DATA_W-1:0]      mem_data_in;
    logic                   mem_data_wr;
    logic [DATA_W-1:0]      ex_data_out;
    logic                   flush;
    logic [OCC_W-1:0]       occupancy;

    modport slave (
        input  id_valid, id_uops, id_uop_count, id_k16,
        input  ex_sched_ack, mem_data_in, mem_data_wr, flush,
        output id_ready, ex_uop_next, ex_uop_valid, ex_uop_last,
        output ex_data_out, occupancy
    );

    modport master (
        output id_valid, id_uops, id_uop_count, id_k16,
        output ex_sched_ack, mem_data_in, mem_data_wr, flush,
        input  id_ready, ex_uop_next, ex_uop_valid, ex_uop_last,
        input  ex_data_out, occupancy
    );

endinterface

// File: rtl/r_station_q_bundle_mem.sv
// DEPTH-entry bundle store: full write at tail, operand write at head,
// asynchronous read of the head entry.
module rs_bundle_mem
    import r_station_pkg::*;
#(
    parameter int unsigned UOP_W  = DEF_UOP_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned SLOTS  = DEF_SLOTS,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned CW    = cnt_w(SLOTS),
    localparam int unsigned PW    = ptr_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   a_rst,
    input  logic                   wr_en,
    input  logic [PW-1:0]          wr_ptr,
    input  logic [CW-1:0]          wr_count,
    input  logic [SLOTS*UOP_W-1:0] wr_uops,
    input  logic [DATA_W-1:0]      wr_operand,
    input  logic                   op_wr_en,
    input  logic [DATA_W-1:0]      op_wr_data,
    input  logic [PW-1:0]          rd_ptr,
    output logic [CW-1:0]          rd_count,
    output logic [SLOTS*UOP_W-1:0] rd_uops,
    output logic [DATA_W-1:0]      rd_operand
);

    logic [CW-1:0]          cnt_q [DEPTH];
    logic [SLOTS*UOP_W-1:0] uop_q [DEPTH];
    logic [DATA_W-1:0]      opr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!a_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                cnt_q[i] <= '0;
                uop_q[i] <= '0;
                opr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (wr_en && wr_ptr == PW'(i)) begin
                    cnt_q[i] <= wr_count;
                    uop_q[i] <= wr_uops;
                    opr_q[i] <= wr_operand;
                end else if (op_wr_en && rd_ptr == PW'(i)) begin
                    opr_q[i] <= op_wr_data;
                end
            end
        end
    end

    assign rd_count   = cnt_q[rd_ptr];
    assign rd_uops    = uop_q[rd_ptr];
    assign rd_operand = opr_q[rd_ptr];

endmodule

// File: rtl/r_station_q.sv
// Bundle reservation station: queues decoded bundles and issues one
// uop per scheduler ack in program order.
module r_station_q
    import r_station_pkg::*;
#(
    parameter int unsigned UOP_W  = DEF_UOP_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned SLOTS  = DEF_SLOTS,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic        clk,
    input  logic        a_rst,
    r_station_q_if.slave bus
);

    localparam int unsigned CW    = cnt_w(SLOTS);
    localparam int unsigned PW    = ptr_w(DEPTH);
    localparam int unsigned OCC_W = cnt_w(DEPTH);
    localparam logic [UOP_W-1:0] NOP = UOP_W'(NOP_UOP);

    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [OCC_W-1:0]       occ;
    logic [CW-1:0]          idx;
    logic [UOP_W-1:0]       last_q;
    logic [CW-1:0]          rd_count;
    logic [SLOTS*UOP_W-1:0] rd_uops;
    logic [DATA_W-1:0]      rd_operand;
    logic [CW-1:0]          st_count;
    logic                   valid;
    logic                   accept;
    logic                   push;
    logic                   fire;
    logic                   pop;
    logic                   op_wr;

    assign st_count = CW'(sat_count(int'(bus.id_uop_count), SLOTS));
    assign valid    = occ != '0;
    assign accept   = bus.id_valid & bus.id_ready;
    // Empty bundles are handshaken away without taking a slot.
    assign push     = accept & (st_count != '0) & ~bus.flush;
    assign fire     = bus.ex_sched_ack & valid;
    assign pop      = fire & (idx == rd_count - CW'(1));
    assign op_wr    = bus.mem_data_wr & valid & ~pop & ~bus.flush;

    assign bus.id_ready     = (occ != OCC_W'(DEPTH)) & a_rst;
    assign bus.ex_uop_valid = valid;
    assign bus.ex_uop_next  = valid
                            ? rd_uops[slot_lsb(idx, UOP_W) +: UOP_W]
                            : NOP;
    assign bus.ex_uop_last  = last_q;
    assign bus.ex_data_out  = valid ? rd_operand : '0;
    assign bus.occupancy    = occ;

    always_ff @(posedge clk) begin
        if (!a_rst) begin
            head   <= '0;
            tail   <= '0;
            occ    <= '0;
            idx    <= '0;
            last_q <= NOP;
        end else if (bus.flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            idx  <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (fire) begin
                last_q <= bus.ex_uop_next;
                if (pop) begin
                    head <= head + PW'(1);
                    idx  <= '0;
                end else begin
                    idx <= idx + CW'(1);
                end
            end
            if (push && !pop) occ <= occ + OCC_W'(1);
            else if (pop && !push) occ <= occ - OCC_W'(1);
        end
    end

    rs_bundle_mem #(
        .UOP_W  (UOP_W),
        .DATA_W (DATA_W),
        .SLOTS  (SLOTS),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk        (clk),
        .a_rst      (a_rst),
        .wr_en      (push),
        .wr_ptr     (tail),
        .wr_count   (st_count),
        .wr_uops    (bus.id_uops),
        .wr_operand (bus.id_k16),
        .op_wr_en   (op_wr),
        .op_wr_data (bus.mem_data_in),
        .rd_ptr     (head),
        .rd_count   (rd_count),
        .rd_uops    (rd_uops),
        .rd_operand (rd_operand)
    );

endmodule

// File: tb/tb_r_station_q.sv
// Directed bench for r_station_q: reset, issue order, backpressure,
// operand overwrite, flush and edge-count scenarios.
module tb_r_station_q;
    import r_station_pkg::*;

    localparam int unsigned UW = 20;
    localparam int unsigned DW = 16;
    localparam int unsigned SL = 3;
    localparam int unsigned DP = 4;

    logic clk = 1'b0;
    logic a_rst;
    int   errs = 0;
    int   checks = 0;

    r_station_q_if #(.UOP_W(UW), .DATA_W(DW), .SLOTS(SL), .DEPTH(DP)) bus ();

    r_station_q #(.UOP_W(UW), .DATA_W(DW), .SLOTS(SL), .DEPTH(DP)) dut (
        .clk   (clk),
        .a_rst (a_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.id_uops      = '0;
        bus.id_uop_count = '0;
        bus.id_k16       = '0;
        bus.ex_sched_ack = 1'b0;
        bus.mem_data_in  = '0;
        bus.mem_data_wr  = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic drive_id(input logic [SL*UW-1:0] u,
                            input logic [1:0] c,
                            input logic [DW-1:0] k);
        bus.id_valid     = 1'b1;
        bus.id_uops      = u;
        bus.id_uop_count = c;
        bus.id_k16       = k;
    endtask

    task automatic test_reset();
        idle();
        a_rst = 1'b0;
        tick();
        tick();
        checks++; if (bus.id_ready !== 1'b0) begin errs++; $display("FAIL rst_ready_low: got %b want 0", bus.id_ready); end
        a_rst = 1'b1;
        #1;
        checks++; if (bus.ex_uop_next !== 20'h00F00) begin errs++; $display("FAIL rst_next: got %h want 00f00", bus.ex_uop_next); end
        checks++; if (bus.ex_uop_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", bus.ex_uop_valid); end
        checks++; if (bus.occupancy !== 3'd0) begin errs++; $display("FAIL rst_occ: got %0d want 0", bus.occupancy); end
        checks++; if (bus.id_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", bus.id_ready); end
        checks++; if (bus.ex_data_out !== 16'h0) begin errs++; $display("FAIL rst_data: got %h want 0", bus.ex_data_out); end
        checks++; if (bus.ex_uop_last !== 20'h00F00) begin errs++; $display("FAIL rst_last: got %h want 00f00", bus.ex_uop_last); end
        bus.ex_sched_ack = 1'b1;
        tick();
        tick();
        bus.ex_sched_ack = 1'b0;
        checks++; if (bus.occupancy !== 3'd0) begin errs++; $display("FAIL idle_ack_occ: got %0d want 0", bus.occupancy); end
        checks++; if (bus.ex_uop_last !== 20'h00F00) begin errs++; $display("FAIL idle_ack_last: got %h want 00f00", bus.ex_uop_last); end
        checks++; if (bus.ex_uop_valid !== 1'b0) begin errs++; $display("FAIL idle_ack_valid: got %b want 0", bus.ex_uop_valid); end
    endtask

    task automatic test_bundle();
        drive_id({20'hCCCC3, 20'hBBBB2, 20'hAAAA1}, 2'd3, 16'h1234);
        #1;
        checks++; if (bus.ex_uop_valid !== 1'b0) begin errs++; $display("FAIL bnd_no_bypass: got %b want 0", bus.ex_uop_valid); end
        tick();
        bus.id_valid = 1'b0;
        checks++; if (bus.occupancy !== 3'd1) begin errs++; $display("FAIL bnd_occ1: got %0d want 1", bus.occupancy); end
        checks++; if (bus.ex_uop_next !== 20'hAAAA1) begin errs++; $display("FAIL bnd_next_a: got %h want aaaa1", bus.ex_uop_next); end
        checks++; if (bus.ex_data_out !== 16'h1234) begin errs++; $display("FAIL bnd_data: got %h want 1234", bus.ex_data_out); end
        bus.ex_sched_ack = 1'b1;
        tick();
        checks++; if (bus.ex_uop_last !== 20'hAAAA1) begin errs++; $display("FAIL bnd_last_a: got %h want aaaa1", bus.ex_uop_last); end
        checks++; if (bus.ex_uop_next !== 20'hBBBB2) begin errs++; $display("FAIL bnd_next_b: got %h want bbbb2", bus.ex_uop_next); end
        tick();
        checks++; if (bus.ex_uop_last !== 20'hBBBB2) begin errs++; $display("FAIL bnd_last_b: got %h want bbbb2", bus.ex_uop_last); end
        checks++; if (bus.ex_uop_next !== 20'hCCCC3) begin errs++; $display("FAIL bnd_next_c: got %h want cccc3", bus.ex_uop_next); end
        checks++; if (bus.ex_data_out !== 16'h1234) begin errs++; $display("FAIL bnd_data_c: got %h want 1234", bus.ex_data_out); end
        checks++; if (bus.occupancy !== 3'd1) begin errs++; $display("FAIL bnd_occ_c: got %0d want 1", bus.occupancy); end
        tick();
        bus.ex_sched_ack = 1'b0;
        checks++; if (bus.ex_uop_last !== 20'hCCCC3) begin errs++; $display("FAIL bnd_last_c: got %h want cccc3", bus.ex_uop_last); end
        checks++; if (bus.occupancy !== 3'd0) begin errs++; $display("FAIL bnd_occ0: got %0d want 0", bus.occupancy); end
        checks++; if (bus.ex_uop_next !== 20'h00F00) begin errs++; $display("FAIL bnd_next_nop: got %h want 00f00", bus.ex_uop_next); end
        checks++; if (bus.ex_data_out !== 16'h0) begin errs++; $display("FAIL bnd_data0: got %h want 0", bus.ex_data_out); end
    endtask

    task automatic test_back_to_back();
        logic [UW-1:0] u;
        for (int i = 0; i < 4; i++) begin
            u = UW'(20'h10000 + i);
            drive_id({40'h0, u}, 2'd1, DW'(16'h0100 + i));
            #1;
            checks++; if (bus.id_ready !== 1'b1) begin errs++; $display("FAIL fill_ready%0d: got %b want 1", i, bus.id_ready); end
            tick();
        end
        checks++; if (bus.occupancy !== 3'd4) begin errs++; $display("FAIL fill_occ4: got %0d want 4", bus.occupancy); end
        checks++; if (bus.id_ready !== 1'b0) begin errs++; $display("FAIL fill_ready_full: got %b want 0", bus.id_ready); end
        drive_id({40'h0, 20'h10004}, 2'd1, 16'h0104);
        tick();
        checks++; if (bus.occupancy !== 3'd4) begin errs++; $display("FAIL fill_stall_occ: got %0d want 4", bus.occupancy); end
        checks++; if (bus.ex_uop_next !== 20'h10000) begin errs++; $display("FAIL fill_head: got %h want 10000", bus.ex_uop_next); end
        bus.ex_sched_ack = 1'b1;
        #1;
        checks++; if (bus.id_ready !== 1'b0) begin errs++; $display("FAIL fill_pop_ready: got %b want 0", bus.id_ready); end
        tick();
        bus.ex_sched_ack = 1'b0;
        checks++; if (bus.occupancy !== 3'd3) begin errs++; $display("FAIL fill_pop_occ: got %0d want 3", bus.occupancy); end
        checks++; if (bus.ex_uop_last !== 20'h10000) begin errs++; $display("FAIL fill_pop_last: got %h want 10000", bus.ex_uop_last); end
        checks++; if (bus.id_ready !== 1'b1) begin errs++; $display("FAIL fill_ready_again: got %b want 1", bus.id_ready); end
        tick();
        bus.id_valid = 1'b0;
        checks++; if (bus.occupancy !== 3'd4) begin errs++; $display("FAIL fill_late_accept: got %0d want 4", bus.occupancy); end
        bus.ex_sched_ack = 1'b1;
        for (int i = 1; i < 5; i++) begin
            u = UW'(20'h10000 + i);
            checks++; if (bus.ex_uop_next !== u) begin errs++; $display("FAIL drain%0d: got %h want %h", i, bus.ex_uop_next, u); end
            checks++; if (bus.ex_data_out !== DW'(16'h0100 + i)) begin errs++; $display("FAIL drain_k%0d: got %h want %h", i, bus.ex_data_out, DW'(16'h0100 + i)); end
            tick();
        end
        bus.ex_sched_ack = 1'b0;
        checks++; if (bus.occupancy !== 3'd0) begin errs++; $display("FAIL drain_occ: got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_mem_write();
        drive_id({20'h30003, 20'h30002, 20'h30001}, 2'd3, 16'h5555);
        tick();
        drive_id({40'h0, 20'h40001}, 2'd1, 16'h7777);
        tick();
        bus.id_valid = 1'b0;
        bus.ex_sched_ack = 1'b1;
        tick();
        bus.ex_sched_ack = 1'b0;
        bus.mem_data_wr = 1'b1;
        bus.mem_data_in = 16'hBEEF;
        #1;
        checks++; if (bus.ex_data_out !== 16'h5555) begin errs++; $display("FAIL mem_before: got %h want 5555", bus.ex_data_out); end
        tick();
        bus.mem_data_wr = 1'b0;
        checks++; if (bus.ex_data_out !== 16'hBEEF) begin errs++; $display("FAIL mem_after: got %h want beef", bus.ex_data_out); end
        checks++; if (bus.ex_uop_next !== 20'h30002) begin errs++; $display("FAIL mem_next: got %h want 30002", bus.ex_uop_next); end
        bus.ex_sched_ack = 1'b1;
        tick();
        bus.mem_data_wr = 1'b1;
        bus.mem_data_in = 16'hDEAD;
        tick();
        bus.mem_data_wr = 1'b0;
        checks++; if (bus.occupancy !== 3'd1) begin errs++; $display("FAIL mem_pop_occ: got %0d want 1", bus.occupancy); end
        checks++; if (bus.ex_data_out !== 16'h7777) begin errs++; $display("FAIL mem_drop: got %h want 7777", bus.ex_data_out); end
        checks++; if (bus.ex_uop_last !== 20'h30003) begin errs++; $display("FAIL mem_last: got %h want 30003", bus.ex_uop_last); end
        checks++; if (bus.ex_uop_next !== 20'h40001) begin errs++; $display("FAIL mem_next_q: got %h want 40001", bus.ex_uop_next); end
        tick();
        bus.ex_sched_ack = 1'b0;
        checks++; if (bus.occupancy !== 3'd0) begin errs++; $display("FAIL mem_empty: got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_flush();
        drive_id({20'h50003, 20'h50002, 20'h50001}, 2'd3, 16'h0F01);
        tick();
        drive_id({40'h0, 20'h51001}, 2'd1, 16'h0F02);
        tick();
        drive_id({40'h0, 20'h52001}, 2'd1, 16'h0F03);
        tick();
        bus.id_valid = 1'b0;
        bus.ex_sched_ack = 1'b1;
        tick();
        bus.ex_sched_ack = 1'b0;
        checks++; if (bus.occupancy !== 3'd3) begin errs++; $display("FAIL fl_pre_occ: got %0d want 3", bus.occupancy); end
        drive_id({40'h0, 20'h5F001}, 2'd1, 16'h0FFF);
        bus.flush = 1'b1;
        bus.ex_sched_ack = 1'b1;
        bus.mem_data_wr = 1'b1;
        bus.mem_data_in = 16'h1111;
        tick();
        idle();
        checks++; if (bus.occupancy !== 3'd0) begin errs++; $display("FAIL fl_occ: got %0d want 0", bus.occupancy); end
        checks++; if (bus.ex_uop_valid !== 1'b0) begin errs++; $display("FAIL fl_valid: got %b want 0", bus.ex_uop_valid); end
        checks++; if (bus.ex_uop_last !== 20'h50001) begin errs++; $display("FAIL fl_last: got %h want 50001", bus.ex_uop_last); end
        tick();
        checks++; if (bus.occupancy !== 3'd0) begin errs++; $display("FAIL fl_absent: got %0d want 0", bus.occupancy); end
        drive_id({20'h0, 20'h60002, 20'h60001}, 2'd2, 16'hABCD);
        tick();
        bus.id_valid = 1'b0;
        checks++; if (bus.ex_uop_next !== 20'h60001) begin errs++; $display("FAIL fl_idx0: got %h want 60001", bus.ex_uop_next); end
        checks++; if (bus.ex_data_out !== 16'hABCD) begin errs++; $display("FAIL fl_k16: got %h want abcd", bus.ex_data_out); end
        bus.ex_sched_ack = 1'b1;
        tick();
        tick();
        bus.ex_sched_ack = 1'b0;
        checks++; if (bus.occupancy !== 3'd0) begin errs++; $display("FAIL fl_drain: got %0d want 0", bus.occupancy); end
        checks++; if (bus.ex_uop_last !== 20'h60002) begin errs++; $display("FAIL fl_drain_last: got %h want 60002", bus.ex_uop_last); end
    endtask

    task automatic test_edges();
        drive_id({20'h7, 20'h7, 20'h7}, 2'd0, 16'h7070);
        #1;
        checks++; if (bus.id_ready !== 1'b1) begin errs++; $display("FAIL zero_ready: got %b want 1", bus.id_ready); end
        tick();
        bus.id_valid = 1'b0;
        checks++; if (bus.occupancy !== 3'd0) begin errs++; $display("FAIL zero_occ: got %0d want 0", bus.occupancy); end
        checks++; if (bus.ex_uop_valid !== 1'b0) begin errs++; $display("FAIL zero_valid: got %b want 0", bus.ex_uop_valid); end
        drive_id({20'h80003, 20'h80002, 20'h80001}, '1, 16'h8080);
        tick();
        bus.id_valid = 1'b0;
        bus.ex_sched_ack = 1'b1;
        tick();
        tick();
        checks++; if (bus.occupancy !== 3'd1) begin errs++; $display("FAIL sat_occ2: got %0d want 1", bus.occupancy); end
        checks++; if (bus.ex_uop_next !== 20'h80003) begin errs++; $display("FAIL sat_next: got %h want 80003", bus.ex_uop_next); end
        tick();
        bus.ex_sched_ack = 1'b0;
        checks++; if (bus.occupancy !== 3'd0) begin errs++; $display("FAIL sat_occ0: got %0d want 0", bus.occupancy); end
        checks++; if (bus.ex_uop_last !== 20'h80003) begin errs++; $display("FAIL sat_last: got %h want 80003", bus.ex_uop_last); end
        drive_id({20'h90003, 20'h90002, 20'h90001}, 2'd3, 16'h4242);
        tick();
        bus.id_valid = 1'b0;
        bus.ex_sched_ack = 1'b1;
        tick();
        a_rst = 1'b0;
        tick();
        checks++; if (bus.occupancy !== 3'd0) begin errs++; $display("FAIL mrst_occ: got %0d want 0", bus.occupancy); end
        checks++; if (bus.ex_uop_valid !== 1'b0) begin errs++; $display("FAIL mrst_valid: got %b want 0", bus.ex_uop_valid); end
        checks++; if (bus.ex_uop_last !== 20'h00F00) begin errs++; $display("FAIL mrst_last: got %h want 00f00", bus.ex_uop_last); end
        checks++; if (bus.id_ready !== 1'b0) begin errs++; $display("FAIL mrst_ready: got %b want 0", bus.id_ready); end
        a_rst = 1'b1;
        bus.ex_sched_ack = 1'b0;
        drive_id({40'h0, 20'hA0001}, 2'd1, 16'h9999);
        tick();
        bus.id_valid = 1'b0;
        checks++; if (bus.ex_uop_next !== 20'hA0001) begin errs++; $display("FAIL post_rst_next: got %h want a0001", bus.ex_uop_next); end
        checks++; if (bus.ex_data_out !== 16'h9999) begin errs++; $display("FAIL post_rst_data: got %h want 9999", bus.ex_data_out); end
        checks++; if (bus.occupancy !== 3'd1) begin errs++; $display("FAIL post_rst_occ: got %0d want 1", bus.occupancy); end
    endtask

    initial begin
        a_rst = 1'b0;
        idle();
        test_reset();
        test_bundle();
        test_back_to_back();
        test_mem_write();
        test_flush();
        test_edges();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
